bus_dma_copier: RTL and testbench

Bus initiator that copies a block of 32-bit words from one bus address range to another over the shared rreq/wreq/addr/wdata/rdata/busy/ack bus. It is the master-side counterpart of the memory-mapped responders, such as internal memory and peripherals. Software or the CPU loads the source, destination and length, then pulses start. The block performs one read followed by one write per word, reports done or error, and sits alongside the CPU as a second bus master behind the arbiter.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_busy_timer.sv | 34 +++
 rtl/bus_dma_copier.sv | 175 +++++++++++++++++
 tb/tb_bus_dma_copier.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared types and constants for the bus DMA copier.
//  Revision    : 1.0
// ============================================================================
package bus_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_READ  = 3'd1;
   localparam state_t ST_WRITE = 3'd2;
   localparam state_t ST_FIN   = 3'd3;
   localparam state_t ST_ERR   = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_NOACK   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ALIGN   = 2'd3;

   localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage
`default_nettype wire

// File: rtl/bus_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_busy_timer
//  Description : Counts consecutive stalled cycles of one bus transfer.
//  Revision    : 1.0
// ============================================================================
module bus_busy_timer #(
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);
   import bus_pkg::*;

   localparam int c_cnt_w = $clog2(BUSY_TIMEOUT + 1);

   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_count <= '0;
      end else if (tick) begin
         r_count <= r_count + c_cnt_w'(1);
      end
   end

   // Fires on the stalled cycle that brings the count up to the limit.
   assign expired = tick && (r_count == c_cnt_w'(BUSY_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/bus_dma_copier.sv
`default_nettype none
// ============================================================================
//  Module      : bus_dma_copier
//  Description : Bus master copying a block of words, one read then one write.
//  Revision    : 1.0
// ============================================================================
module bus_dma_copier #(
   parameter int BUSY_TIMEOUT = 16,
   parameter int LEN_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             active,
   output logic             done,
   output logic             error,
   output logic [1:0]       err_code,
   output logic [31:0]      err_addr,
   output logic             rreq,
   output logic             wreq,
   output logic [31:0]      addr,
   output logic [31:0]      wdata,
   input  logic [31:0]      rdata,
   input  logic             busy,
   input  logic             ack
);
   import bus_pkg::*;

   state_t           r_state;
   logic             r_active;
   logic             r_done;
   logic             r_error;
   logic [1:0]       r_err_code;
   logic [31:0]      r_err_addr;
   logic             r_rreq;
   logic             r_wreq;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_idx;

   logic w_in_xfer;
   logic w_stall;
   logic w_expired;

   assign w_in_xfer = (r_state == ST_READ) || (r_state == ST_WRITE);
   assign w_stall   = w_in_xfer && ack && busy;

   bus_busy_timer #(
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) u_busy_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!w_stall),
      .tick    (w_stall),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= ERR_NONE;
         r_err_addr <= '0;
         r_rreq     <= 1'b0;
         r_wreq     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_src      <= '0;
         r_dst      <= '0;
         r_len      <= '0;
         r_idx      <= '0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_active   <= 1'b1;
                  r_err_code <= ERR_NONE;
                  r_err_addr <= '0;
                  r_src      <= src_addr;
                  r_dst      <= dst_addr;
                  r_len      <= len;
                  r_idx      <= '0;
                  if (src_addr[1:0] != 2'b00) begin
                     r_state    <= ST_ERR;
                     r_err_code <= ERR_ALIGN;
                     r_err_addr <= src_addr;
                  end else if (dst_addr[1:0] != 2'b00) begin
                     r_state    <= ST_ERR;
                     r_err_code <= ERR_ALIGN;
                     r_err_addr <= dst_addr;
                  end else if (len == '0) begin
                     r_state <= ST_FIN;
                  end else begin
                     r_state <= ST_READ;
                     r_rreq  <= 1'b1;
                     r_addr  <= src_addr;
                  end
               end
            end

            ST_READ, ST_WRITE: begin
               if (!ack || w_expired) begin
                  r_state    <= ST_ERR;
                  r_rreq     <= 1'b0;
                  r_wreq     <= 1'b0;
                  r_err_code <= ack ? ERR_TIMEOUT : ERR_NOACK;
                  r_err_addr <= r_addr;
               end else if (!busy) begin
                  if (r_state == ST_READ) begin
                     r_wdata <= rdata;
                     r_rreq  <= 1'b0;
                     r_wreq  <= 1'b1;
                     r_addr  <= r_dst;
                     r_state <= ST_WRITE;
                  end else begin
                     // Next read issues straight after the write completes.
                     r_wreq <= 1'b0;
                     r_idx  <= r_idx + LEN_W'(1);
                     r_src  <= r_src + WORD_BYTES;
                     r_dst  <= r_dst + WORD_BYTES;
                     if (r_idx + LEN_W'(1) == r_len) begin
                        r_state <= ST_FIN;
                     end else begin
                        r_rreq  <= 1'b1;
                        r_addr  <= r_src + WORD_BYTES;
                        r_state <= ST_READ;
                     end
                  end
               end
            end

            ST_FIN: begin
               r_done   <= 1'b1;
               r_active <= 1'b0;
               r_state  <= ST_IDLE;
            end

            ST_ERR: begin
               r_error  <= 1'b1;
               r_active <= 1'b0;
               r_state  <= ST_IDLE;
            end

            default: begin
               r_state  <= ST_IDLE;
               r_active <= 1'b0;
               r_rreq   <= 1'b0;
               r_wreq   <= 1'b0;
            end
         endcase
      end
   end

   assign active   = r_active;
   assign done     = r_done;
   assign error    = r_error;
   assign err_code = r_err_code;
   assign err_addr = r_err_addr;
   assign rreq     = r_rreq;
   assign wreq     = r_wreq;
   assign addr     = r_addr;
   assign wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_dma_copier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_dma_copier
//  Description : Self-checking bench with an 8K-word memory responder at base 0.
//  Revision    : 1.0
// ============================================================================
module tb_bus_dma_copier;

   localparam int BUSY_TIMEOUT = 16;
   localparam int LEN_W        = 16;
   localparam int MEM_WORDS    = 8192;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [LEN_W-1:0] len;
   logic             active;
   logic             done;
   logic             error;
   logic [1:0]       err_code;
   logic [31:0]      err_addr;
   logic             rreq;
   logic             wreq;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             busy;
   logic             ack;

   int errors      = 0;
   int checks      = 0;
   int read_lat    = 0;
   int held        = 0;
   int req_cycles  = 0;
   int both_high   = 0;

   logic [31:0] mem [0:MEM_WORDS-1];

   bus_dma_copier #(
      .BUSY_TIMEOUT (BUSY_TIMEOUT),
      .LEN_W        (LEN_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .active   (active),
      .done     (done),
      .error    (error),
      .err_code (err_code),
      .err_addr (err_addr),
      .rreq     (rreq),
      .wreq     (wreq),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .ack      (ack)
   );

   always #5 clk = ~clk;

   // Responder: decodes 0..0x7FFF, stalls each read for read_lat cycles.
   assign ack   = (rreq || wreq) && (addr < 32'h0000_8000);
   assign busy  = rreq && ack && (held < read_lat);
   assign rdata = (rreq && ack) ? mem[addr[14:2]] : 32'h0;

   always @(posedge clk) begin
      if (rreq || wreq) req_cycles++;
      if (rreq && wreq) both_high++;
      if ((rreq || wreq) && ack && !busy) begin
         if (wreq) mem[addr[14:2]] <= wdata;
         held <= 0;
      end else if (rreq || wreq) begin
         held <= held + 1;
      end else begin
         held <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the first cycle after the start-acceptance edge.
   task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n);
      src_addr = s;
      dst_addr = d;
      len      = LEN_W'(n);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Returns the cycle index (1 = first cycle after start) of done/error, 0 if none.
   task automatic wait_end(input int budget, output int cyc, output logic got_done,
                           output logic got_err);
      cyc      = 0;
      got_done = 1'b0;
      got_err  = 1'b0;
      for (int n = 1; n <= budget; n++) begin
         if (done || error) begin
            cyc      = n;
            got_done = done;
            got_err  = error;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int          cyc;
      logic        gd;
      logic        ge;
      int          rc;
      int          n;
      int          lat;
      int          sw;
      int          dw;
      logic [31:0] exp_q [$];

      reset    = 1'b1;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;
      for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'h0;
      repeat (3) tick();

      check("rst_active",   32'(active),   32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_error",    32'(error),    32'd0);
      check("rst_rreq",     32'(rreq),     32'd0);
      check("rst_wreq",     32'(wreq),     32'd0);
      check("rst_addr",     addr,          32'd0);
      check("rst_wdata",    wdata,         32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_err_addr", err_addr,      32'd0);
      reset = 1'b0;
      tick();

      // Four-word copy with one busy cycle per read: 3 cycles per word.
      exp_q = {32'h11, 32'h22, 32'h33, 32'h44};
      for (int k = 0; k < 4; k++) mem[4 + k] = exp_q[k];
      read_lat = 1;
      launch(32'h10, 32'h100, 4);
      check("copy4_active", 32'(active), 32'd1);
      wait_end(200, cyc, gd, ge);
      check("copy4_cycle",    32'(cyc),      32'(4 * 3 + 2));
      check("copy4_done",     32'(gd),       32'd1);
      check("copy4_err_code", 32'(err_code), 32'd0);
      tick();
      check("copy4_one_pulse", 32'(done),   32'd0);
      check("copy4_idle",      32'(active), 32'd0);
      for (int k = 0; k < 4; k++) check($sformatf("copy4_word%0d", k), mem[64 + k], exp_q[k]);

      // Zero length: no bus traffic, done two cycles after start.
      rc = req_cycles;
      launch(32'h20, 32'h200, 0);
      check("len0_active_c1", 32'(active), 32'd1);
      wait_end(20, cyc, gd, ge);
      check("len0_cycle",     32'(cyc),        32'd2);
      check("len0_done",      32'(gd),         32'd1);
      check("len0_active_c2", 32'(active),     32'd0);
      check("len0_no_req",    32'(req_cycles), 32'(rc));

      // Misaligned source, then misaligned destination.
      rc = req_cycles;
      launch(32'h12, 32'h200, 3);
      wait_end(20, cyc, gd, ge);
      check("src_align_cycle", 32'(cyc),        32'd2);
      check("src_align_err",   32'(ge),         32'd1);
      check("src_align_code",  32'(err_code),   32'd3);
      check("src_align_addr",  err_addr,        32'h12);
      check("src_align_noreq", 32'(req_cycles), 32'(rc));
      repeat (3) tick();
      check("err_code_hold",   32'(err_code),   32'd3);
      launch(32'h10, 32'h202, 1);
      wait_end(20, cyc, gd, ge);
      check("dst_align_err",   32'(ge),         32'd1);
      check("dst_align_code",  32'(err_code),   32'd3);
      check("dst_align_addr",  err_addr,        32'h202);

      // Destination outside the responder: first write is not acknowledged.
      read_lat = 0;
      launch(32'h10, 32'h9000, 2);
      wait_end(50, cyc, gd, ge);
      check("noack_cycle", 32'(cyc),      32'd4);
      check("noack_err",   32'(ge),       32'd1);
      check("noack_done",  32'(gd),       32'd0);
      check("noack_code",  32'(err_code), 32'd1);
      check("noack_addr",  err_addr,      32'h9000);
      tick();

      // Read stalled beyond the limit: 16 busy cycles, then abort.
      read_lat = 20;
      launch(32'h40, 32'h300, 1);
      repeat (15) tick();
      check("tmo_rreq_c16", 32'(rreq),     32'd1);
      tick();
      check("tmo_rreq_c17", 32'(rreq),     32'd0);
      tick();
      check("tmo_err",      32'(error),    32'd1);
      check("tmo_code",     32'(err_code), 32'd2);
      check("tmo_addr",     err_addr,      32'h40);
      tick();

      // Reset during the write of the second word of four.
      read_lat = 0;
      launch(32'h10, 32'h400, 4);
      for (int k = 0; k < 50; k++) begin
         if (wreq && addr == 32'h404) break;
         tick();
      end
      check("rst_mid_found", addr, 32'h404);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_rreq",   32'(rreq),   32'd0);
      check("rst_mid_wreq",   32'(wreq),   32'd0);
      check("rst_mid_active", 32'(active), 32'd0);
      tick();
      check("rst_mid_nodone", 32'(done),   32'd0);
      check("rst_mid_noerr",  32'(error),  32'd0);
      launch(32'h10, 32'h400, 4);
      wait_end(100, cyc, gd, ge);
      check("rst_after_cycle", 32'(cyc), 32'(4 * 2 + 2));
      check("rst_after_done",  32'(gd),  32'd1);
      for (int k = 0; k < 4; k++) check($sformatf("rst_after_word%0d", k), mem[256 + k], exp_q[k]);
      tick();

      // Randomized copies between disjoint regions with random read latency.
      for (int it = 0; it < 6; it++) begin
         lat = int'($urandom_range(0, 2));
         n   = int'($urandom_range(1, 8));
         sw  = int'($urandom_range(0, 1023));
         dw  = 2048 + int'($urandom_range(0, 1023));
         exp_q.delete();
         for (int k = 0; k < n; k++) begin
            exp_q.push_back($urandom);
            mem[sw + k] = exp_q[k];
            mem[dw + k] = ~exp_q[k];
         end
         read_lat = lat;
         launch(32'(sw * 4), 32'(dw * 4), n);
         wait_end(400, cyc, gd, ge);
         check($sformatf("rnd%0d_cycle", it), 32'(cyc),      32'(n * (2 + lat) + 2));
         check($sformatf("rnd%0d_done", it),  32'(gd),       32'd1);
         check($sformatf("rnd%0d_code", it),  32'(err_code), 32'd0);
         for (int k = 0; k < n; k++)
            check($sformatf("rnd%0d_word%0d", it, k), mem[dw + k], exp_q[k]);
         tick();
      end

      check("bus_exclusive", 32'(both_high), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
